// File: rtl/dram_cache_axi_master.sv
// dram_cache_axi_master: single-outstanding AXI initiator for DRAM-cache tag+data lines
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   i/o req_*                line read/write request from the cache controller
//   o/i rsp_*                response with returned tag/line and hit/dirty/timeout flags
//   arid_o..rready_o         AXI read address and read data channels
//   awid_o..bready_o         AXI write address, write data and write response channels
module dram_cache_axi_master #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 512,
  parameter int unsigned TAG_S       = 64,
  parameter int unsigned ID_W        = 16,
  parameter int unsigned AXI_ID      = 1,
  parameter int unsigned INDEX_W     = 26,
  parameter int unsigned OFFSET_W    = 6,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic                    req_dirty_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [DATA_W-1:0]       req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_write_o,
  output logic [TAG_S-1:0]        rsp_tag_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rsp_hit_o,
  output logic                    rsp_dirty_o,
  output logic                    rsp_err_o,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic [ID_W-1:0]         rid_i,
  input  logic [TAG_S+DATA_W-1:0] rdata_i,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  output logic [ID_W-1:0]         awid_o,
  output logic [ADDR_W-1:0]       awaddr_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [ID_W-1:0]         wid_o,
  output logic [DATA_W-1:0]       wdata_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  input  logic [ID_W-1:0]         bid_i,
  input  logic                    bvalid_i,
  output logic                    bready_o
);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CMP_LO = INDEX_W + OFFSET_W;
  localparam int unsigned CMP_W  = ADDR_W - 1 - CMP_LO;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RSP} state_t;
  state_t             r_state, w_next;
  logic               r_live, r_write, r_dirty, r_aw_done, r_w_done;
  logic [ADDR_W-2:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata, r_data;
  logic [TAG_S-1:0]   r_tag;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept, w_busy, w_unused;
  assign w_accept = req_valid_i && req_ready_o;
  assign w_busy   = r_state inside {S_AR, S_R, S_AWW, S_B};
  // IDs are never checked and bit 63 of the request address is replaced on the bus
  assign w_unused = ^{rid_i, bid_i, req_addr_i[ADDR_W-1]};
  always_ff @(posedge clk)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // AW and W complete independently; a handshake in this cycle counts as done
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = req_write_i ? S_AWW : S_AR;
      S_AR:    if (arready_i) w_next = S_R;
      S_R:     if (rvalid_i) w_next = S_RSP;
      S_AWW:   if ((r_aw_done || awready_i) && (r_w_done || wready_i)) w_next = S_B;
      S_B:     if (bvalid_i) w_next = S_RSP;
      S_RSP:   if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // r_live keeps req_ready_o low while reset is held even though the state is IDLE
  always_comb begin
    req_ready_o = r_live && r_state == S_IDLE;
    arvalid_o   = r_state == S_AR;
    rready_o    = r_state == S_R;
    awvalid_o   = r_state == S_AWW && !r_aw_done;
    wvalid_o    = r_state == S_AWW && !r_w_done;
    bready_o    = r_state == S_B;
    rsp_valid_o = r_state == S_RSP;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_live    <= 1'b0;
      r_write   <= 1'b0;
      r_dirty   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tag     <= '0;
      r_data    <= '0;
      r_cnt     <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_write   <= req_write_i;
        r_dirty   <= req_dirty_i;
        r_addr    <= req_addr_i[ADDR_W-2:0];
        r_wdata   <= req_wdata_i;
        r_tag     <= '0;
        r_data    <= '0;
        r_cnt     <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_busy && r_cnt != CNT_W'(TIMEOUT_CYC)) r_cnt <= r_cnt + CNT_W'(1);
        if (awvalid_o && awready_i) r_aw_done <= 1'b1;
        if (wvalid_o && wready_i) r_w_done <= 1'b1;
        if (rready_o && rvalid_i) begin
          r_tag  <= rdata_i[TAG_S+DATA_W-1:DATA_W];
          r_data <= rdata_i[DATA_W-1:0];
        end
      end
    end
  assign arid_o      = ID_W'(AXI_ID);
  assign awid_o      = ID_W'(AXI_ID);
  assign wid_o       = ID_W'(AXI_ID);
  assign araddr_o    = {1'b0, r_addr};
  assign awaddr_o    = {r_dirty, r_addr};
  assign wdata_o     = r_wdata;
  assign rsp_write_o = r_write;
  assign rsp_tag_o   = r_tag;
  assign rsp_data_o  = r_data;
  // tag layout: [63] valid, [62] dirty, then the address bits above index+offset
  assign rsp_hit_o   = r_tag[TAG_S-1] && r_tag[TAG_S-4 -: CMP_W] == r_addr[ADDR_W-2 -: CMP_W];
  assign rsp_dirty_o = r_tag[TAG_S-2];
  assign rsp_err_o   = r_cnt == CNT_W'(TIMEOUT_CYC);
endmodule

// File: tb/tb_dram_cache_axi_master.sv
// tb_dram_cache_axi_master: directed table plus random transactions against a line-memory model
module tb_dram_cache_axi_master;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_i, req_ready_o, req_write_i, req_dirty_i;
  logic [63:0] req_addr_i;
  logic [511:0] req_wdata_i;
  logic rsp_valid_o, rsp_ready_i, rsp_write_o, rsp_hit_o, rsp_dirty_o, rsp_err_o;
  logic [63:0] rsp_tag_o;
  logic [511:0] rsp_data_o;
  logic [15:0] arid_o, rid_i, awid_o, wid_o, bid_i;
  logic [63:0] araddr_o, awaddr_o;
  logic arvalid_o, arready_i, rvalid_i, rready_o;
  logic [575:0] rdata_i;
  logic awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [511:0] wdata_o;
  always #5 clk = ~clk;
  dram_cache_axi_master #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_dirty_i(req_dirty_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o), .rsp_hit_o(rsp_hit_o),
    .rsp_dirty_o(rsp_dirty_o), .rsp_err_o(rsp_err_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );
  typedef struct {
    logic wr, dirty;
    logic [63:0] addr;
    logic [511:0] wdata;
    int d1, d2, d3, hold;
    logic hit, dty, err;
  } vec_t;
  int n_vec = 0, n_bad = 0;
  string ctx = "reset";
  logic [575:0] smem [logic [25:0]];
  logic [575:0] mmem [logic [25:0]];
  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", ctx, nm, act, exp);
    end
  endtask
  function automatic logic [63:0] mk_tag(input logic d, input logic [63:0] a);
    return {1'b1, d, 1'b0, a[62:32], 30'b0};
  endfunction
  function automatic logic [575:0] mline(input logic [63:0] a);
    if (mmem.exists(a[31:6])) return mmem[a[31:6]];
    return '0;
  endfunction
  function automatic logic [575:0] sline(input logic [25:0] i);
    if (smem.exists(i)) return smem[i];
    return '0;
  endfunction
  function automatic int busy_of(input vec_t v);
    if (!v.wr) return v.d1 + v.d2 + 2;
    return (v.d1 > v.d2 ? v.d1 : v.d2) + v.d3 + 2;
  endfunction
  function automatic vec_t mkv(input logic wr, input logic dirty, input logic [63:0] addr,
                               input logic [511:0] wd, input int d1, input int d2, input int d3,
                               input int hold, input logic hit, input logic dty, input logic err);
    vec_t v;
    v.wr = wr; v.dirty = dirty; v.addr = addr; v.wdata = wd;
    v.d1 = d1; v.d2 = d2; v.d3 = d3; v.hold = hold;
    v.hit = hit; v.dty = dty; v.err = err;
    return v;
  endfunction
  function automatic vec_t fill(input vec_t v);
    logic [575:0] l;
    vec_t r;
    r = v;
    l = v.wr ? 576'h0 : mline(v.addr);
    r.hit = l[575] && l[572:542] == v.addr[62:32];
    r.dty = l[574];
    r.err = busy_of(v) >= TO;
    return r;
  endfunction
  task automatic idle_inputs();
    arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0; rsp_ready_i = 0;
  endtask
  task automatic run(input vec_t v);
    int busy, p1, rc;
    logic [575:0] el;
    logic [63:0] cap_a;
    logic [511:0] cap_w;
    busy = busy_of(v);
    p1 = v.wr ? (v.d1 > v.d2 ? v.d1 : v.d2) + 1 : v.d1 + 1;
    rc = busy + 1;
    el = v.wr ? 576'h0 : mline(v.addr);
    cap_a = '0;
    cap_w = '0;
    req_valid_i = 1; req_write_i = v.wr; req_dirty_i = v.dirty;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    chk("req_ready_start", req_ready_o, 1);
    for (int c = 1; c <= rc + v.hold; c++) begin
      @(negedge clk);
      idle_inputs();
      req_valid_i = c >= rc && c < rc + v.hold;
      if (c <= p1) begin
        if (v.wr) begin
          chk("awvalid", awvalid_o, c <= v.d1 + 1);
          chk("wvalid", wvalid_o, c <= v.d2 + 1);
          chk("bready", bready_o, 0);
          if (c <= v.d1 + 1) chk("awaddr", awaddr_o, {v.dirty, v.addr[62:0]});
          if (c <= v.d2 + 1) chk("wdata", wdata_o, v.wdata);
        end else begin
          chk("arvalid", arvalid_o, 1);
          chk("araddr", araddr_o, {1'b0, v.addr[62:0]});
          chk("rready", rready_o, 0);
        end
      end else if (c <= busy) begin
        if (v.wr) begin
          chk("awvalid_drop", awvalid_o, 0);
          chk("wvalid_drop", wvalid_o, 0);
          chk("bready", bready_o, 1);
        end else begin
          chk("arvalid_drop", arvalid_o, 0);
          chk("rready", rready_o, 1);
        end
      end else begin
        chk("rsp_valid", rsp_valid_o, 1);
        chk("rsp_write", rsp_write_o, v.wr);
        chk("rsp_tag", rsp_tag_o, el[575:512]);
        chk("rsp_data", rsp_data_o, el[511:0]);
        chk("rsp_hit", rsp_hit_o, v.hit);
        chk("rsp_dirty", rsp_dirty_o, v.dty);
        chk("rsp_err", rsp_err_o, v.err);
        chk("req_ready_rsp", req_ready_o, 0);
        chk("no_new_ar", arvalid_o | awvalid_o | wvalid_o, 0);
      end
      if (c <= busy) begin
        chk("rsp_valid_busy", rsp_valid_o, 0);
        chk("req_ready_busy", req_ready_o, 0);
      end
      if (!v.wr) begin
        arready_i = c == v.d1 + 1;
        if (c == v.d1 + 1) cap_a = araddr_o;
        rvalid_i = c == busy;
        rdata_i = sline(cap_a[31:6]);
      end else begin
        awready_i = c == v.d1 + 1;
        if (c == v.d1 + 1) cap_a = awaddr_o;
        wready_i = c == v.d2 + 1;
        if (c == v.d2 + 1) cap_w = wdata_o;
        bvalid_i = c == busy;
        if (c == busy) smem[cap_a[31:6]] = {mk_tag(cap_a[63], cap_a), cap_w};
      end
      rsp_ready_i = c == rc + v.hold;
    end
    @(negedge clk);
    idle_inputs();
    req_valid_i = 0;
    chk("rsp_valid_end", rsp_valid_o, 0);
    chk("req_ready_end", req_ready_o, 1);
    if (v.wr) mmem[v.addr[31:6]] = {mk_tag(v.dirty, v.addr), v.wdata};
  endtask
  vec_t tbl[15];
  vec_t rv;
  initial begin
    req_valid_i = 0; req_write_i = 0; req_dirty_i = 0; req_addr_i = '0; req_wdata_i = '0;
    rid_i = 16'h3; bid_i = 16'h7; rdata_i = '0;
    idle_inputs();
    tbl[0]  = mkv(0, 0, 64'h0000_0001_0000_0040, '0, 1, 0, 0, 0, 1, 0, 0);
    tbl[1]  = mkv(1, 0, 64'h0000_0002_0000_0080, {64{8'hA5}}, 2, 2, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 0, 64'h0000_0002_0000_0080, '0, 1, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mkv(1, 1, 64'h0000_0003_0000_0080, {64{8'h3C}}, 2, 2, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0, 64'h0000_0005_0000_0080, '0, 1, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mkv(1, 0, 64'h0000_0000_0000_00C0, {64{8'h5A}}, 0, 2, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(1, 1, 64'h0000_0000_0000_0100, {64{8'h96}}, 3, 1, 1, 0, 0, 0, 0);
    tbl[7]  = mkv(1, 0, 64'h0000_0000_0000_0140, {64{8'hC3}}, 1, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 64'h0000_0000_0000_00C0, '0, 3, 0, 0, 5, 1, 0, 0);
    tbl[9]  = mkv(0, 0, 64'h0000_0001_0000_0040, '0, 10, 10, 0, 0, 1, 0, 1);
    tbl[10] = mkv(1, 1, 64'h0000_0000_0000_0100, {64{8'h77}}, 5, 7, 6, 0, 0, 0, 1);
    tbl[11] = mkv(0, 0, 64'h0000_0001_0000_0040, '0, 4, 1, 0, 0, 1, 0, 0);
    tbl[12] = mkv(0, 0, 64'h0000_0001_0000_0040, '0, 4, 2, 0, 0, 1, 0, 1);
    tbl[13] = mkv(0, 0, 64'h0000_0000_0000_0100, '0, 1, 0, 0, 2, 1, 1, 0);
    tbl[14] = mkv(0, 0, 64'h0000_0000_0000_0400, '0, 1, 0, 0, 0, 0, 0, 0);
    smem[26'd1] = {64'h8000_0000_4000_0000, {8{64'h0123_4567_89AB_CDEF}}};
    mmem[26'd1] = {64'h8000_0000_4000_0000, {8{64'h0123_4567_89AB_CDEF}}};
    repeat (3) @(negedge clk);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_bready", bready_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_tag", rsp_tag_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_rsp_flags", {rsp_write_o, rsp_hit_o, rsp_dirty_o, rsp_err_o}, 0);
    chk("arid", arid_o, 1);
    chk("awid", awid_o, 1);
    chk("wid", wid_o, 1);
    rst_n = 1;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready_o, 1);
    for (int i = 0; i < 15; i++) begin
      ctx = $sformatf("dir%0d", i);
      run(tbl[i]);
    end
    for (int i = 0; i < 40; i++) begin
      ctx = $sformatf("rnd%0d", i);
      rv.wr = 1'($urandom); rv.dirty = 1'($urandom);
      rv.addr = '0;
      rv.addr[63] = 1'($urandom);
      rv.addr[33:32] = 2'($urandom);
      rv.addr[8:6] = 3'($urandom);
      rv.addr[5:0] = 6'($urandom);
      for (int k = 0; k < 16; k++) rv.wdata[k*32 +: 32] = $urandom;
      rv.d1 = $urandom_range(0, 3); rv.d2 = $urandom_range(0, 3);
      rv.d3 = $urandom_range(0, 3); rv.hold = $urandom_range(0, 2);
      run(fill(rv));
    end
    ctx = "rst_aww";
    req_valid_i = 1; req_write_i = 1; req_dirty_i = 1;
    req_addr_i = 64'h0000_0000_0000_0500; req_wdata_i = {64{8'hEE}};
    @(negedge clk);
    chk("aww_entered", awvalid_o & wvalid_o, 1);
    req_valid_i = 0;
    rst_n = 0;
    @(negedge clk);
    chk("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, rsp_valid_o}, 0);
    chk("rst_req_ready", req_ready_o, 0);
    rst_n = 1;
    @(negedge clk);
    chk("release_req_ready", req_ready_o, 1);
    chk("release_valids", {arvalid_o, awvalid_o, wvalid_o}, 0);
    ctx = "after_rst";
    run(fill(mkv(0, 0, 64'h0000_0000_0000_0500, '0, 1, 0, 0, 0, 0, 0, 0)));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
